wb_stream_loader: RTL and testbench
===================================

WB_STREAM_LOADER -- requirements
Module: wb_stream_loader

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles to wait for wb_ack_i per write before the load is aborted.
REQ-002 clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 data_i  input  8  byte stream payload.
REQ-005 valid_i  input  1  data_i holds a valid byte.
REQ-006 ready_o  output  1  loader accepts data_i this cycle; a byte transfers when valid_i and ready_o are both high.
REQ-007 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone master cycle, strobe and write-enable.
REQ-008 wb_adr_o  output  32  Wishbone byte address.
REQ-009 wb_dat_o  output  32  Wishbone write data.
REQ-010 wb_sel_o  output  4  byte selects.
REQ-011 wb_ack_i, wb_err_i  input  1 each  slave acknowledge and error.
REQ-012 halt_core_o  output  1  holds the core halted while loading.
REQ-013 core_rst_o  output  1  one-cycle core reset pulse on load completion.
REQ-014 done_o, error_o  output  1 each  sticky completion and failure flags.

Function
REQ-015 The stream format SHALL be: 4-byte start address, 4-byte word count N, then 4*N data bytes, all little-endian (first byte = bits 7:0).
REQ-016 States SHALL be HDR_ADDR, HDR_LEN, DATA, WRITE, DONE, ERROR.
REQ-017 ready_o SHALL be 1 only in HDR_ADDR, HDR_LEN and DATA, and 0 in all other states.
REQ-018 A 2-bit byte counter SHALL assemble each 32-bit field; the field completes on its 4th accepted byte, and the counter then wraps to 0.
REQ-019 HDR_ADDR: on field completion, go to ERROR if address bits 1:0 are nonzero; otherwise latch the address and go to HDR_LEN.
REQ-020 HDR_LEN: on field completion, latch N; go to DONE if N==0, otherwise go to DATA.
REQ-021 DATA: on the 4th accepted byte, go to WRITE; wb_cyc_o, wb_stb_o and wb_we_o SHALL assert in the cycle after that byte, with wb_sel_o=4'hF, wb_adr_o=current address and wb_dat_o=assembled word.
REQ-022 WRITE: all Wishbone outputs SHALL be held stable until wb_ack_i, wb_err_i or timeout.
REQ-023 On wb_ack_i, the loader SHALL deassert cyc/stb/we in the next cycle, add 4 to the address (modulo 2^32, 0xFFFFFFFC wraps to 0) and decrement the remaining count; it SHALL go to DONE if the count reaches 0, otherwise back to DATA.
REQ-024 wb_err_i in WRITE SHALL take priority over a simultaneous wb_ack_i, and the loader SHALL go to ERROR.
REQ-025 A wait counter SHALL reset on entry to WRITE; if TIMEOUT cycles pass without wb_ack_i or wb_err_i, the loader SHALL go to ERROR.
REQ-026 In every cycle outside WRITE, wb_cyc_o, wb_stb_o and wb_we_o SHALL be 0.
REQ-027 halt_core_o SHALL be 1 in every state except DONE.
REQ-028 core_rst_o SHALL be 1 for exactly the first cycle in DONE.
REQ-029 DONE and ERROR SHALL be terminal: they are left only by rst_i, and input bytes presented in them are ignored.
REQ-030 done_o SHALL be 1 in DONE, and error_o SHALL be 1 in ERROR.
REQ-031 valid_i low SHALL stall field assembly with no state loss; gaps of any length SHALL be allowed between bytes.

Reset
REQ-032 While rst_i is 1, the state SHALL be HDR_ADDR, all counters and the address/data/count registers 0, and outputs SHALL be: halt_core_o=1, ready_o=0, all Wishbone outputs 0, core_rst_o=0, done_o=0, error_o=0.
REQ-033 ready_o SHALL first assert in the cycle after rst_i deasserts.
REQ-034 rst_i asserted mid-transfer, including during WRITE, SHALL drop cyc/stb that same edge and discard all partial state.

Structure
REQ-035 The state enum and the header field length constant (4 bytes) SHALL live in a shared package, alongside the Wishbone bus typedefs.
REQ-036 Byte-to-word assembly SHALL be one sub-module, byte_packer: 8-bit in, 32-bit out, word-complete strobe.
REQ-037 halt_core_o and core_rst_o SHALL connect directly to the core subsystem's halt input and reset-request path, and the Wishbone port SHALL occupy one master slot of the interconnect.

Verification
REQ-038 Bytes 00 00 00 00 | 02 00 00 00 | 78 56 34 12 | EF BE AD DE, slave acks after 1 cycle -> writes 0x12345678@0x0 and 0xDEADBEEF@0x4, sel=F; then done_o=1, halt_core_o=0, core_rst_o pulses for one cycle.
REQ-039 Header address 0x02, count 1 -> error_o=1 after the 4th byte; no Wishbone cycle; ready_o=0.
REQ-040 Count 0 -> DONE immediately after the 8th byte; no Wishbone cycle.
REQ-041 Slave never acks (TIMEOUT=16) -> cyc held for exactly 16 cycles, then error_o=1 and halt_core_o stays 1.
REQ-042 wb_err_i and wb_ack_i asserted together on word 1 -> ERROR; word 2 is never written.
REQ-043 rst_i pulsed while stb is high -> stb=0 on the next edge; a fresh stream then loads correctly, with valid_i toggled randomly throughout.

Source files
------------

// File: rtl/wb_stream_loader_pkg.sv
// rtl/wb_stream_loader_pkg.sv - shared states, field length and Wishbone bus types for the stream loader
package wb_stream_loader_pkg;

    // Number of bytes that make up one header or data field
    localparam int HDR_FIELD_BYTES = 4;

    typedef enum logic [2:0] {
        HDR_ADDR = 3'd0,
        HDR_LEN  = 3'd1,
        DATA     = 3'd2,
        WRITE    = 3'd3,
        DONE     = 3'd4,
        ERROR    = 3'd5
    } loader_state_t;

    // Master-to-slave half of a Wishbone bus
    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } wb_m2s_t;

    // Slave-to-master half of a Wishbone bus (write-only master, so no read data)
    typedef struct packed {
        logic ack;
        logic err;
    } wb_s2m_t;

endpackage

// File: rtl/wb_stream_loader_byte_packer.sv
// rtl/wb_stream_loader_byte_packer.sv - assembles little-endian bytes into 32-bit words
module byte_packer
    import wb_stream_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  data_i,
    input  logic        take_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);

    logic [1:0]  r_cnt;
    logic [23:0] r_low;

    // Byte counter and storage of the three lower bytes of the word in progress
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= 2'd0;
            r_low <= 24'd0;
        end else if (take_i) begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
                2'd0:    r_low[7:0]   <= data_i;
                2'd1:    r_low[15:8]  <= data_i;
                2'd2:    r_low[23:16] <= data_i;
                default: r_low        <= r_low;
            endcase
        end
    end

    // The top byte comes straight from the input so the word is usable on its completing cycle
    assign word_o      = {data_i, r_low};
    assign word_done_o = take_i && (r_cnt == 2'(HDR_FIELD_BYTES - 1));

endmodule

// File: rtl/wb_stream_loader.sv
// rtl/wb_stream_loader.sv - loads a byte stream into memory over Wishbone while holding the core halted
module wb_stream_loader
    import wb_stream_loader_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  data_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    output logic        halt_core_o,
    output logic        core_rst_o,
    output logic        done_o,
    output logic        error_o
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [31:0]       r_addr;
    logic [31:0]       r_count;
    logic [31:0]       r_wdata;
    logic [WAIT_W-1:0] r_wait;
    logic              r_done_seen;

    logic [31:0]       w_word;
    logic              w_word_done;
    logic              w_take;
    logic              w_wait_expired;
    wb_m2s_t           w_wb;
    wb_s2m_t           w_wb_in;

    assign w_wb_in.ack    = wb_ack_i;
    assign w_wb_in.err    = wb_err_i;
    assign w_take         = valid_i && ready_o;
    assign w_wait_expired = (r_wait == WAIT_W'(TIMEOUT - 1));

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .take_i      (w_take),
        .word_o      (w_word),
        .word_done_o (w_word_done)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= HDR_ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and all outputs; reset forces every output to its idle value immediately
    always_comb begin
        w_next      = r_state;
        ready_o     = 1'b0;
        w_wb        = '0;
        halt_core_o = 1'b1;
        core_rst_o  = 1'b0;
        done_o      = 1'b0;
        error_o     = 1'b0;
        case (r_state)
            HDR_ADDR: begin
                ready_o = 1'b1;
                if (w_word_done) begin
                    w_next = (w_word[1:0] != 2'b00) ? ERROR : HDR_LEN;
                end
            end
            HDR_LEN: begin
                ready_o = 1'b1;
                if (w_word_done) begin
                    w_next = (w_word == 32'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                ready_o = 1'b1;
                if (w_word_done) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                w_wb.cyc = 1'b1;
                w_wb.stb = 1'b1;
                w_wb.we  = 1'b1;
                w_wb.adr = r_addr;
                w_wb.dat = r_wdata;
                w_wb.sel = 4'hF;
                if (w_wb_in.err) begin
                    w_next = ERROR;
                end else if (w_wb_in.ack) begin
                    w_next = (r_count == 32'd1) ? DONE : DATA;
                end else if (w_wait_expired) begin
                    w_next = ERROR;
                end
            end
            DONE: begin
                halt_core_o = 1'b0;
                done_o      = 1'b1;
                core_rst_o  = !r_done_seen;
            end
            ERROR: begin
                error_o = 1'b1;
            end
            default: begin
                w_next = HDR_ADDR;
            end
        endcase
        if (rst_i) begin
            ready_o     = 1'b0;
            w_wb        = '0;
            halt_core_o = 1'b1;
            core_rst_o  = 1'b0;
            done_o      = 1'b0;
            error_o     = 1'b0;
        end
    end

    assign wb_cyc_o = w_wb.cyc;
    assign wb_stb_o = w_wb.stb;
    assign wb_we_o  = w_wb.we;
    assign wb_adr_o = w_wb.adr;
    assign wb_dat_o = w_wb.dat;
    assign wb_sel_o = w_wb.sel;

    // Address, remaining count, write data, ack wait counter and first-DONE-cycle tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr      <= 32'd0;
            r_count     <= 32'd0;
            r_wdata     <= 32'd0;
            r_wait      <= '0;
            r_done_seen <= 1'b0;
        end else begin
            case (r_state)
                HDR_ADDR: begin
                    if (w_word_done && (w_word[1:0] == 2'b00)) begin
                        r_addr <= w_word;
                    end
                end
                HDR_LEN: begin
                    if (w_word_done) begin
                        r_count <= w_word;
                    end
                end
                DATA: begin
                    if (w_word_done) begin
                        r_wdata <= w_word;
                        r_wait  <= '0;
                    end
                end
                WRITE: begin
                    if (!w_wb_in.err) begin
                        if (w_wb_in.ack) begin
                            r_addr  <= r_addr + 32'd4;
                            r_count <= r_count - 32'd1;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_done_seen <= 1'b1;
                end
                default: begin
                    r_done_seen <= r_done_seen;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stream_loader.sv
// tb/tb_wb_stream_loader.sv - directed self-checking bench for wb_stream_loader
module tb_wb_stream_loader;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;
    logic        halt_core_o, core_rst_o, done_o, error_o;

    int tests    = 0;
    int failures = 0;

    // Slave behaviour: 0 = ack after ack_lat cycles, 1 = never respond, 2 = err+ack together
    int slave_mode = 0;
    int ack_lat    = 1;
    int run        = 0;
    int last_run   = 0;
    int stb_total  = 0;
    int err_cnt    = 0;
    int crst_cnt   = 0;
    bit rand_gaps  = 0;
    logic [31:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    logic [3:0]  wr_sel[$];

    wb_stream_loader #(.TIMEOUT(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_we_o     (wb_we_o),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_sel_o    (wb_sel_o),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .halt_core_o (halt_core_o),
        .core_rst_o  (core_rst_o),
        .done_o      (done_o),
        .error_o     (error_o)
    );

    always #5 clk_i = ~clk_i;

    // Wishbone slave and core-reset pulse monitor, evaluated on the falling edge
    initial begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (core_rst_o) crst_cnt++;
            if (wb_cyc_o && wb_stb_o) begin
                run++;
                stb_total++;
                if (slave_mode != 1 && run > ack_lat && !wb_ack_i) begin
                    wb_ack_i = 1'b1;
                    if (slave_mode == 2) begin
                        wb_err_i = 1'b1;
                        err_cnt++;
                    end else begin
                        wr_adr.push_back(wb_adr_o);
                        wr_dat.push_back(wb_dat_o);
                        wr_sel.push_back(wb_sel_o);
                    end
                end else begin
                    wb_ack_i = 1'b0;
                    wb_err_i = 1'b0;
                end
            end else begin
                if (run != 0) last_run = run;
                run      = 0;
                wb_ack_i = 1'b0;
                wb_err_i = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        if (rand_gaps) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk_i);
                valid_i = 1'b0;
                data_i  = 8'($urandom);
            end
        end
        @(negedge clk_i);
        data_i  = b;
        valid_i = 1'b1;
        n = 0;
        while (!ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 100) check("send_byte_ready_timeout", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!done_o && !error_o && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i   = 1'b1;
        valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        wr_adr.delete();
        wr_dat.delete();
        wr_sel.delete();
        stb_total = 0;
        err_cnt   = 0;
        crst_cnt  = 0;
        last_run  = 0;
        rst_i     = 1'b0;
    endtask

    initial begin
        rst_i   = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;

        // Reset state
        repeat (3) tick();
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_halt", 32'(halt_core_o), 32'd1);
        check("rst_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        check("rst_adr", wb_adr_o, 32'd0);
        check("rst_flags", {29'd0, core_rst_o, done_o, error_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();
        check("ready_after_rst", 32'(ready_o), 32'd1);

        // Two-word load with 1-cycle ack
        slave_mode = 0;
        ack_lat    = 1;
        send_word(32'h0000_0000);
        send_word(32'h0000_0002);
        send_word(32'h1234_5678);
        tick();
        check("w1_cyc_stb_we", {29'd0, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd7);
        check("w1_adr", wb_adr_o, 32'h0);
        check("w1_dat", wb_dat_o, 32'h1234_5678);
        check("w1_sel", 32'(wb_sel_o), 32'hF);
        check("w1_ready_low", 32'(ready_o), 32'd0);
        send_word(32'hDEAD_BEEF);
        wait_end();
        repeat (3) tick();
        check("load_nwrites", 32'(wr_adr.size()), 32'd2);
        if (wr_adr.size() == 2) begin
            check("load_adr0", wr_adr[0], 32'h0);
            check("load_dat0", wr_dat[0], 32'h1234_5678);
            check("load_adr1", wr_adr[1], 32'h4);
            check("load_dat1", wr_dat[1], 32'hDEAD_BEEF);
            check("load_sel1", 32'(wr_sel[1]), 32'hF);
        end
        check("load_done", 32'(done_o), 32'd1);
        check("load_halt", 32'(halt_core_o), 32'd0);
        check("load_core_rst_pulses", 32'(crst_cnt), 32'd1);
        check("load_ready_done", 32'(ready_o), 32'd0);
        check("load_cyc_idle", 32'(wb_cyc_o), 32'd0);

        // Misaligned address
        do_reset();
        send_word(32'h0000_0002);
        tick();
        check("misal_error", 32'(error_o), 32'd1);
        check("misal_ready", 32'(ready_o), 32'd0);
        check("misal_halt", 32'(halt_core_o), 32'd1);
        data_i  = 8'h01;
        valid_i = 1'b1;
        repeat (6) tick();
        valid_i = 1'b0;
        check("misal_still_error", {30'd0, done_o, error_o}, 32'd1);
        check("misal_no_wb", 32'(stb_total), 32'd0);

        // Zero word count
        do_reset();
        send_word(32'h0000_0010);
        send_word(32'h0000_0000);
        tick();
        check("zero_done", 32'(done_o), 32'd1);
        check("zero_core_rst_first", 32'(core_rst_o), 32'd1);
        tick();
        check("zero_core_rst_second", 32'(core_rst_o), 32'd0);
        check("zero_halt", 32'(halt_core_o), 32'd0);
        check("zero_no_wb", 32'(stb_total), 32'd0);

        // Slave never acks: timeout
        do_reset();
        slave_mode = 1;
        send_word(32'h0000_0100);
        send_word(32'h0000_0001);
        send_word(32'hCAFE_F00D);
        wait_end();
        repeat (2) tick();
        check("to_error", 32'(error_o), 32'd1);
        check("to_halt", 32'(halt_core_o), 32'd1);
        check("to_cyc_len", 32'(last_run), 32'd16);
        check("to_cyc_idle", 32'(wb_cyc_o), 32'd0);

        // err and ack together on word 1
        do_reset();
        slave_mode = 2;
        send_word(32'h0000_0020);
        send_word(32'h0000_0002);
        send_word(32'hAAAA_5555);
        wait_end();
        data_i  = 8'h77;
        valid_i = 1'b1;
        repeat (8) tick();
        valid_i = 1'b0;
        check("err_error", 32'(error_o), 32'd1);
        check("err_done_low", 32'(done_o), 32'd0);
        check("err_writes", 32'(wr_adr.size()), 32'd0);
        check("err_one_cycle_only", 32'(err_cnt), 32'd1);
        check("err_stb_cycles", 32'(stb_total), 32'd2);

        // Reset during strobe, then a fresh gapped load
        do_reset();
        slave_mode = 1;
        send_word(32'h0000_0040);
        send_word(32'h0000_0001);
        send_word(32'h0BAD_0BAD);
        tick();
        check("mid_stb_high", 32'(wb_stb_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("mid_stb_dropped", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        do_reset();
        slave_mode = 0;
        ack_lat    = 1;
        rand_gaps  = 1;
        send_word(32'h0000_1000);
        send_word(32'h0000_0002);
        send_word(32'h1122_3344);
        send_word(32'h5566_7788);
        wait_end();
        rand_gaps = 0;
        check("fresh_done", 32'(done_o), 32'd1);
        check("fresh_nwrites", 32'(wr_adr.size()), 32'd2);
        if (wr_adr.size() == 2) begin
            check("fresh_adr0", wr_adr[0], 32'h0000_1000);
            check("fresh_dat0", wr_dat[0], 32'h1122_3344);
            check("fresh_adr1", wr_adr[1], 32'h0000_1004);
            check("fresh_dat1", wr_dat[1], 32'h5566_7788);
        end

        // Address wrap with slow slave holding outputs stable
        do_reset();
        slave_mode = 0;
        ack_lat    = 3;
        send_word(32'hFFFF_FFFC);
        send_word(32'h0000_0002);
        send_word(32'h0102_0304);
        tick();
        check("wrap_adr_first", wb_adr_o, 32'hFFFF_FFFC);
        tick();
        tick();
        check("hold_cyc", 32'(wb_cyc_o), 32'd1);
        check("hold_adr", wb_adr_o, 32'hFFFF_FFFC);
        check("hold_dat", wb_dat_o, 32'h0102_0304);
        send_word(32'hA0B0_C0D0);
        wait_end();
        check("wrap_done", 32'(done_o), 32'd1);
        check("wrap_nwrites", 32'(wr_adr.size()), 32'd2);
        if (wr_adr.size() == 2) begin
            check("wrap_adr1", wr_adr[1], 32'h0);
            check("wrap_dat1", wr_dat[1], 32'hA0B0_C0D0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
